// File: rtl/mic_conditioner.sv
// rtl/mic_conditioner.sv - multi-channel mic DC-offset calibration, offset removal and decimation
// Optional peak meter: define MIC_COND_PEAK_EN.
module mic_conditioner #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 10,
  parameter int DECIM    = 2
) (
  input  logic                    audio_clk,
  input  logic                    rst_in,
  input  logic                    sample_valid_in,
  input  logic [NUM_CH*WIDTH-1:0] audio_in,
  input  logic                    cal_trigger_in,
`ifdef MIC_COND_PEAK_EN
  input  logic                    peak_clr_in,
  output logic [NUM_CH*WIDTH-1:0] peak_out,
`endif
  output logic                    cal_busy_out,
  output logic                    cal_done_out,
  output logic [NUM_CH*WIDTH-1:0] audio_out,
  output logic                    valid_out
);

  localparam int AW = WIDTH + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, LOAD} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           phase_q;
  logic signed [AW-1:0]    acc_q    [NUM_CH];
  logic signed [WIDTH-1:0] offset_q [NUM_CH];
  logic signed [WIDTH-1:0] offset_d [NUM_CH];
  logic signed [WIDTH-1:0] x        [NUM_CH];
  logic signed [WIDTH-1:0] y        [NUM_CH];
  logic [NUM_CH*WIDTH-1:0] audio_out_q;
  logic                    valid_q;
  logic                    done_q;

  // Difference taken one bit wider so the sign of the true result is never lost.
  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    if (d[WIDTH] != d[WIDTH-1]) return d[WIDTH] ? SMIN : SMAX;
    return d[WIDTH-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      x[k]        = audio_in[k*WIDTH +: WIDTH];
      y[k]        = sat_sub(x[k], offset_q[k]);
      offset_d[k] = WIDTH'(acc_q[k] >>> AVG_LOG2);
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      audio_out_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        acc_q[k]    <= '0;
        offset_q[k] <= '0;
      end
    end else begin
      valid_q <= sample_valid_in && (phase_q == '0);
      if (sample_valid_in) begin
        phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
        if (phase_q == '0) begin
          for (int k = 0; k < NUM_CH; k++) audio_out_q[k*WIDTH +: WIDTH] <= y[k];
        end
      end
      // A trigger coinciding with a sample discards that sample from the window.
      case (state_q)
        IDLE: begin
          if (cal_trigger_in) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
          end
        end
        ACCUM: begin
          if (cal_trigger_in) begin
            cnt_q <= '0;
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
          end else if (sample_valid_in) begin
            cnt_q <= cnt_q + CW'(1);
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_q[k] + AW'(x[k]);
            if (cnt_q == CNT_LAST) state_q <= LOAD;
          end
        end
        LOAD: begin
          for (int k = 0; k < NUM_CH; k++) offset_q[k] <= offset_d[k];
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cal_busy_out = (state_q == ACCUM);
  assign cal_done_out = done_q;
  assign audio_out    = audio_out_q;
  assign valid_out    = valid_q;

`ifdef MIC_COND_PEAK_EN
  logic [WIDTH-1:0] mag      [NUM_CH];
  logic [WIDTH-1:0] peak_q   [NUM_CH];

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (!y[k][WIDTH-1])  mag[k] = y[k];
      else if (y[k] == SMIN) mag[k] = SMAX;
      else                 mag[k] = -y[k];
      peak_out[k*WIDTH +: WIDTH] = peak_q[k];
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      for (int k = 0; k < NUM_CH; k++) peak_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (sample_valid_in) begin
          if (peak_clr_in || (mag[k] > peak_q[k])) peak_q[k] <= mag[k];
        end else if (peak_clr_in) begin
          peak_q[k] <= '0;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mic_conditioner.sv
// tb/tb_mic_conditioner.sv - self-checking bench for mic_conditioner (NUM_CH=2, WIDTH=16, AVG_LOG2=2, DECIM=2)
module tb_mic_conditioner;

  localparam int NUM_CH = 2;
  localparam int WIDTH = 16;
  localparam int AVG_LOG2 = 2;
  localparam int DECIM = 2;
  localparam int NAVG = 1 << AVG_LOG2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    sample_valid_in = 1'b0;
  logic [NUM_CH*WIDTH-1:0] audio_in = '0;
  logic                    cal_trigger_in = 1'b0;
  logic                    cal_busy_out;
  logic                    cal_done_out;
  logic [NUM_CH*WIDTH-1:0] audio_out;
  logic                    valid_out;
`ifdef MIC_COND_PEAK_EN
  logic                    peak_clr = 1'b0;
  logic [NUM_CH*WIDTH-1:0] peak_out;
`endif

  mic_conditioner #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2), .DECIM(DECIM)) dut (
    .audio_clk      (clk),
    .rst_in         (rst_n),
    .sample_valid_in(sample_valid_in),
    .audio_in       (audio_in),
    .cal_trigger_in (cal_trigger_in),
`ifdef MIC_COND_PEAK_EN
    .peak_clr_in    (peak_clr),
    .peak_out       (peak_out),
`endif
    .cal_busy_out   (cal_busy_out),
    .cal_done_out   (cal_done_out),
    .audio_out      (audio_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model state: offsets, running sums, sample count, pending load
  int m_off[2], m_sum[2];
  int m_n, m_phase;
  bit m_cal, m_load, m_done;

  int nxt_valid, nxt_busy, nxt_done, nxt_out0, nxt_out1;
  int exp_valid, exp_busy, exp_done, exp_out0, exp_out1;

  task automatic chk(input string nm, input int act, input int ex);
    n_checks++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, ex);
    end
  endtask

  function automatic int sat(input int d);
    if (d > 32767) return 32767;
    if (d < -32768) return -32768;
    return d;
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_off[0] = 0; m_off[1] = 0; m_sum[0] = 0; m_sum[1] = 0;
    m_n = 0; m_phase = 0; m_cal = 0; m_load = 0; m_done = 0;
    nxt_valid = 0; nxt_busy = 0; nxt_done = 0; nxt_out0 = 0; nxt_out1 = 0;
  endtask

  always @(posedge clk) begin
    exp_valid <= nxt_valid;
    exp_busy  <= nxt_busy;
    exp_done  <= nxt_done;
    exp_out0  <= nxt_out0;
    exp_out1  <= nxt_out1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_out", int'(valid_out), exp_valid);
      chk("cal_busy_out", int'(cal_busy_out), exp_busy);
      chk("cal_done_out", int'(cal_done_out), exp_done);
      chk("audio_out_ch0", int'($signed(audio_out[15:0])), exp_out0);
      chk("audio_out_ch1", int'($signed(audio_out[31:16])), exp_out1);
    end
  end

  task automatic step(input bit v, input int a0, input int a1, input bit trig);
    logic [15:0] s0, s1;
    @(negedge clk);
    s0 = 16'(a0);
    s1 = 16'(a1);
    sample_valid_in = v;
    cal_trigger_in  = trig;
    audio_in        = {s1, s0};
    nxt_valid = 0;
    if (v) begin
      if (m_phase == 0) begin
        nxt_valid = 1;
        nxt_out0  = sat(a0 - m_off[0]);
        nxt_out1  = sat(a1 - m_off[1]);
      end
      m_phase = (m_phase + 1) % DECIM;
    end
    if (m_load) begin
      m_off[0] = floor_div(m_sum[0], NAVG);
      m_off[1] = floor_div(m_sum[1], NAVG);
      m_done = 1;
      m_load = 0;
    end else if (trig) begin
      m_cal = 1; m_sum[0] = 0; m_sum[1] = 0; m_n = 0;
    end else if (m_cal && v) begin
      m_sum[0] += a0; m_sum[1] += a1; m_n++;
      if (m_n == NAVG) begin
        m_cal = 0;
        m_load = 1;
      end
    end
    nxt_busy = m_cal;
    nxt_done = m_done;
    @(posedge clk);
  endtask

  task automatic do_reset();
    #2;
    rst_n  = 1'b0;
    chk_en = 1'b0;
    #1;
    chk("rst_valid_out", int'(valid_out), 0);
    chk("rst_audio_out", int'(audio_out != '0), 0);
    chk("rst_busy", int'(cal_busy_out), 0);
    chk("rst_done", int'(cal_done_out), 0);
    model_reset();
    @(negedge clk);
    sample_valid_in = 1'b0;
    cal_trigger_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
  endtask

  initial begin
    int pulses;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: four samples give two output strobes, then async reset mid-cycle
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 7 + i, -7 - i, 0);
      #1 pulses += int'(valid_out);
      step(0, 0, 0, 0);
    end
    chk("t1_pulse_count", pulses, 2);
    step(1, 1, 1, 0);
    do_reset();

    // 2: uncalibrated pass-through
    step(1, 100, -50, 0);
    #1;
    chk("t2_valid", int'(valid_out), 1);
    chk("t2_ch0", int'($signed(audio_out[15:0])), 100);
    chk("t2_ch1", int'($signed(audio_out[31:16])), -50);
    step(1, 100, -50, 0);
    #1 chk("t2_no_valid", int'(valid_out), 0);
    step(1, 100, -50, 0);
    step(1, 100, -50, 0);

    // 3: calibration
    step(0, 0, 0, 1);
    step(1, 10, -3, 0);
    step(1, 12, -3, 0);
    step(1, 14, -3, 0);
    #1 chk("t3_busy_mid", int'(cal_busy_out), 1);
    step(1, 16, -2, 0);
    #1 chk("t3_busy_end", int'(cal_busy_out), 0);
    step(0, 0, 0, 0);
    #1 chk("t3_done", int'(cal_done_out), 1);

    // 4: offsets 13 / -3 applied
    step(1, 20, 0, 0);
    #1;
    chk("t4_ch0", int'($signed(audio_out[15:0])), 7);
    chk("t4_ch1", int'($signed(audio_out[31:16])), 3);
    step(1, 20, 0, 0);

    // 5: saturation
    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, -32768, 32767, 0);
    step(0, 0, 0, 0);
    step(1, 32767, -32768, 0);
    #1;
    chk("t5_ch0", int'($signed(audio_out[15:0])), 32767);
    chk("t5_ch1", int'($signed(audio_out[31:16])), -32768);
    step(1, 32767, -32768, 0);

    // 6: restart keeps old offsets in force, then reset during ACCUM
    step(0, 0, 0, 1);
    step(1, 100, 100, 0);
    step(1, 100, 100, 0);
    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    #1;
    chk("t6_old_off_ch0", int'($signed(audio_out[15:0])), 32767);
    chk("t6_old_off_ch1", int'($signed(audio_out[31:16])), -32767);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    #1 chk("t6_busy_3", int'(cal_busy_out), 1);
    step(1, 0, 0, 0);
    #1 chk("t6_busy_4", int'(cal_busy_out), 0);
    step(0, 0, 0, 0);
    step(1, -9, 9, 0);
    #1 chk("t6_new_off_ch0", int'($signed(audio_out[15:0])), -9);
    step(0, 0, 0, 1);
    step(1, 5, 5, 0);
    do_reset();
    step(1, 1234, -4321, 0);
    #1;
    chk("t6_post_rst_ch0", int'($signed(audio_out[15:0])), 1234);
    chk("t6_post_rst_ch1", int'($signed(audio_out[31:16])), -4321);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
